// File: rtl/encode_prefix_stream.sv
// encode_prefix_stream: serialises one request of prefix flags into IA-32 prefix
// bytes, one per cycle, in group order 1..4. Branch hints: PREFIX_BRANCH_HINT_EN.
module encode_prefix_stream #(
  parameter int MAX_PREFIX = 4
) (
  input  logic       i_clock,
  input  logic       i_reset_n,
  input  logic       i_req_valid,
  output logic       o_req_ready,
  input  logic       i_lock,
  input  logic       i_repeat_not_equal,
  input  logic       i_repeat_equal,
  input  logic       i_segment_override,
  input  logic [2:0] i_segment_index,
  input  logic       i_operand_size,
  input  logic       i_address_size,
`ifdef PREFIX_BRANCH_HINT_EN
  input  logic       i_hint_branch_not_taken,
  input  logic       i_hint_branch_taken,
`endif
  output logic       o_byte_valid,
  output logic [7:0] o_byte,
  input  logic       i_byte_ready,
  output logic       o_done,
  output logic [2:0] o_prefix_count,
  output logic       o_error
);

  // state | meaning
  // IDLE  | waiting for a request, o_req_ready high
  // EMIT  | presenting the current slot's byte until it is accepted
  // DONE  | one-cycle completion pulse carrying count and error

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EMIT = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0] state_q;
  logic [3:0] slot_mask_q;
  logic [1:0] slot_q;
  logic [7:0] g1_byte_q;
  logic [7:0] g2_byte_q;
  logic [2:0] count_q;
  logic       err_q;

  logic       g1_multi;
  logic       seg_bad;
  logic       g2_present;
  logic       req_err;
  logic [3:0] req_mask;
  logic [7:0] req_g1_byte;
  logic [7:0] req_g2_byte;
  logic       accept;
  logic       handshake;
  logic [2:0] first_slot;
  logic [2:0] next_slot;

  // Returns {found, index} of the lowest present slot at or above start.
  function automatic logic [2:0] find_slot(input logic [3:0] mask, input logic [2:0] start);
    logic [2:0] r;
    r = 3'b000;
    for (int i = 3; i >= 0; i--) begin
      if (mask[i] && (3'(i) >= start)) r = {1'b1, 2'(i)};
    end
    return r;
  endfunction

  assign g1_multi = (i_lock & i_repeat_not_equal) |
                    (i_lock & i_repeat_equal) |
                    (i_repeat_not_equal & i_repeat_equal);
  assign seg_bad  = i_segment_override & (i_segment_index > 3'd5);

`ifdef PREFIX_BRANCH_HINT_EN
  logic hint_any;
  logic hint_bad;
  assign hint_any   = i_hint_branch_not_taken | i_hint_branch_taken;
  assign hint_bad   = (i_hint_branch_not_taken & i_hint_branch_taken) |
                      (hint_any & i_segment_override);
  assign g2_present = i_segment_override | hint_any;
  assign req_err    = g1_multi | seg_bad | hint_bad;
`else
  assign g2_present = i_segment_override;
  assign req_err    = g1_multi | seg_bad;
`endif

  assign req_mask = {i_address_size, i_operand_size, g2_present,
                     i_lock | i_repeat_not_equal | i_repeat_equal};

  always_comb begin
    req_g1_byte = 8'h00;
    if (i_lock)                  req_g1_byte = 8'hF0;
    else if (i_repeat_not_equal) req_g1_byte = 8'hF2;
    else if (i_repeat_equal)     req_g1_byte = 8'hF3;
  end

  always_comb begin
    req_g2_byte = 8'h00;
    case (i_segment_index)
      3'd0:    req_g2_byte = 8'h26;
      3'd1:    req_g2_byte = 8'h2E;
      3'd2:    req_g2_byte = 8'h36;
      3'd3:    req_g2_byte = 8'h3E;
      3'd4:    req_g2_byte = 8'h64;
      3'd5:    req_g2_byte = 8'h65;
      default: req_g2_byte = 8'h00;
    endcase
`ifdef PREFIX_BRANCH_HINT_EN
    // A hint combined with a segment override is rejected, so it may simply win here.
    if (i_hint_branch_not_taken)  req_g2_byte = 8'h2E;
    else if (i_hint_branch_taken) req_g2_byte = 8'h3E;
`endif
  end

  assign o_req_ready  = (state_q == S_IDLE);
  assign accept       = i_req_valid & o_req_ready;
  assign o_byte_valid = (state_q == S_EMIT);
  assign handshake    = o_byte_valid & i_byte_ready;
  assign first_slot   = find_slot(req_mask, 3'd0);
  assign next_slot    = find_slot(slot_mask_q, {1'b0, slot_q} + 3'd1);

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q     <= S_IDLE;
      slot_mask_q <= 4'b0000;
      slot_q      <= 2'd0;
      g1_byte_q   <= 8'h00;
      g2_byte_q   <= 8'h00;
      count_q     <= 3'd0;
      err_q       <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            g1_byte_q <= req_g1_byte;
            g2_byte_q <= req_g2_byte;
            count_q   <= 3'd0;
            slot_q    <= first_slot[1:0];
            if (req_err) begin
              err_q       <= 1'b1;
              slot_mask_q <= 4'b0000;
              state_q     <= S_DONE;
            end else begin
              err_q       <= 1'b0;
              slot_mask_q <= req_mask;
              state_q     <= first_slot[2] ? S_EMIT : S_DONE;
            end
          end
        end
        S_EMIT: begin
          if (handshake) begin
            if (count_q < 3'(MAX_PREFIX)) count_q <= count_q + 3'd1;
            if (next_slot[2]) slot_q  <= next_slot[1:0];
            else              state_q <= S_DONE;
          end
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    o_byte = 8'h00;
    if (state_q == S_EMIT) begin
      case (slot_q)
        2'd0:    o_byte = g1_byte_q;
        2'd1:    o_byte = g2_byte_q;
        2'd2:    o_byte = 8'h66;
        default: o_byte = 8'h67;
      endcase
    end
  end

  assign o_done         = (state_q == S_DONE);
  assign o_prefix_count = o_done ? count_q : 3'd0;
  assign o_error        = o_done & err_q;

endmodule

// File: tb/tb_encode_prefix_stream.sv
// Bench for encode_prefix_stream: directed vector table, hand-written corner
// sequences and randomized requests against a queue-based reference model.
module tb_encode_prefix_stream;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       i_req_valid;
  logic       o_req_ready;
  logic       i_lock, i_repeat_not_equal, i_repeat_equal, i_segment_override;
  logic [2:0] i_segment_index;
  logic       i_operand_size, i_address_size;
`ifdef PREFIX_BRANCH_HINT_EN
  logic       i_hint_branch_not_taken, i_hint_branch_taken;
`endif
  logic       o_byte_valid;
  logic [7:0] o_byte;
  logic       i_byte_ready;
  logic       o_done;
  logic [2:0] o_prefix_count;
  logic       o_error;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  encode_prefix_stream #(.MAX_PREFIX(4)) dut (
    .i_clock(clk), .i_reset_n(rst_n),
    .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
    .i_lock(i_lock), .i_repeat_not_equal(i_repeat_not_equal),
    .i_repeat_equal(i_repeat_equal), .i_segment_override(i_segment_override),
    .i_segment_index(i_segment_index), .i_operand_size(i_operand_size),
    .i_address_size(i_address_size),
`ifdef PREFIX_BRANCH_HINT_EN
    .i_hint_branch_not_taken(i_hint_branch_not_taken),
    .i_hint_branch_taken(i_hint_branch_taken),
`endif
    .o_byte_valid(o_byte_valid), .o_byte(o_byte), .i_byte_ready(i_byte_ready),
    .o_done(o_done), .o_prefix_count(o_prefix_count), .o_error(o_error)
  );

  typedef struct packed {
    logic       lock, rne, re, seg;
    logic [2:0] idx;
    logic       osz, asz;
`ifdef PREFIX_BRANCH_HINT_EN
    logic       hnt, ht;
`endif
  } req_t;

  typedef struct packed {
    req_t        req;
    logic [31:0] bytes;   // first byte in [31:24]
    logic [2:0]  n;
    logic        err;
  } vec_t;

  typedef logic [7:0] bq_t[$];

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  function automatic req_t mk(input logic lock, input logic rne, input logic re, input logic seg,
                              input logic [2:0] idx, input logic osz, input logic asz);
    req_t r;
    r = '0;
    r.lock = lock; r.rne = rne; r.re = re; r.seg = seg;
    r.idx = idx; r.osz = osz; r.asz = asz;
    return r;
  endfunction

  function automatic req_t rand_req();
    req_t r;
    r = '0;
    r.lock = ($urandom_range(0, 3) == 0);
    r.rne  = ($urandom_range(0, 3) == 0);
    r.re   = ($urandom_range(0, 3) == 0);
    r.seg  = ($urandom_range(0, 1) == 0);
    r.idx  = 3'($urandom_range(0, 7));
    r.osz  = ($urandom_range(0, 1) == 0);
    r.asz  = ($urandom_range(0, 1) == 0);
`ifdef PREFIX_BRANCH_HINT_EN
    r.hnt  = ($urandom_range(0, 4) == 0);
    r.ht   = ($urandom_range(0, 4) == 0);
`endif
    return r;
  endfunction

  // Reference: byte list built directly from the prefix-group rules.
  function automatic void model(input req_t r, output bq_t q, output bit err);
    logic [7:0] seg_tbl [8];
    seg_tbl = '{8'h26, 8'h2E, 8'h36, 8'h3E, 8'h64, 8'h65, 8'h00, 8'h00};
    q = {};
    err = ($countones({r.lock, r.rne, r.re}) > 1) || (r.seg && (r.idx > 3'd5));
`ifdef PREFIX_BRANCH_HINT_EN
    err = err || (r.hnt && r.ht) || ((r.hnt || r.ht) && r.seg);
`endif
    if (!err) begin
      if (r.lock)     q.push_back(8'hF0);
      else if (r.rne) q.push_back(8'hF2);
      else if (r.re)  q.push_back(8'hF3);
      if (r.seg) q.push_back(seg_tbl[r.idx]);
`ifdef PREFIX_BRANCH_HINT_EN
      else if (r.hnt) q.push_back(8'h2E);
      else if (r.ht)  q.push_back(8'h3E);
`endif
      if (r.osz) q.push_back(8'h66);
      if (r.asz) q.push_back(8'h67);
    end
  endfunction

  function automatic bq_t to_q(input logic [31:0] b, input int n);
    bq_t q;
    q = {};
    for (int i = 0; i < n; i++) q.push_back(b[31-8*i -: 8]);
    return q;
  endfunction

  task automatic drive_req(input req_t r);
    i_lock = r.lock; i_repeat_not_equal = r.rne; i_repeat_equal = r.re;
    i_segment_override = r.seg; i_segment_index = r.idx;
    i_operand_size = r.osz; i_address_size = r.asz;
`ifdef PREFIX_BRANCH_HINT_EN
    i_hint_branch_not_taken = r.hnt; i_hint_branch_taken = r.ht;
`endif
  endtask

  // Issues one request and follows it to o_done; request inputs carry junk while busy.
  task automatic run_req(input req_t r, input int first_stall, input int stall_pct,
                         output bq_t got, output int cnt, output bit err,
                         output int cycles, output int stalls, output bit timed_out);
    logic [7:0] prev;
    bit held, rdy;
    int first_held;
    got = {}; stalls = 0; held = 0; first_held = 0; timed_out = 1;
    cnt = 0; err = 0; prev = 8'h00;
    @(negedge clk);
    check("req_ready_idle", 32'(o_req_ready), 32'd1);
    check("done_pulse_end", 32'(o_done), 32'd0);
    drive_req(r);
    i_req_valid  = 1'b1;
    i_byte_ready = 1'b0;
    for (cycles = 1; cycles <= 200; cycles++) begin
      @(negedge clk);
      if (o_done) begin
        cnt = int'(o_prefix_count);
        err = o_error;
        timed_out = 0;
        i_req_valid = 1'b0;
        i_byte_ready = 1'b0;
        break;
      end
      check("req_ready_busy", 32'(o_req_ready), 32'd0);
      check("error_idle", 32'(o_error), 32'd0);
      if (o_byte_valid) begin
        if (held) check("byte_hold", 32'(o_byte), 32'(prev));
        if (got.size() == 0 && first_held < first_stall) rdy = 0;
        else rdy = ($urandom_range(0, 99) >= stall_pct);
        if (!rdy) begin
          stalls++;
          if (got.size() == 0) first_held++;
        end else got.push_back(o_byte);
        prev = o_byte;
        held = !rdy;
        i_byte_ready = rdy;
      end else begin
        if (held) check("valid_hold", 32'(o_byte_valid), 32'd1);
        held = 0;
        i_byte_ready = 1'($urandom_range(0, 1));
      end
      i_req_valid = 1'($urandom_range(0, 1));
      drive_req(rand_req());
    end
  endtask

  task automatic run_and_check(input string tag, input req_t r, input bq_t exp, input bit exp_err,
                               input int first_stall, input int stall_pct, output int stalls);
    bq_t got;
    int cnt, cycles;
    bit err, to;
    run_req(r, first_stall, stall_pct, got, cnt, err, cycles, stalls, to);
    if (to) begin
      tests++; fails++;
      $display("FAIL %s timeout: got no o_done expected o_done within 200 cycles", tag);
    end else begin
      check({tag, "_count"}, 32'(cnt), 32'(exp.size()));
      check({tag, "_error"}, 32'(err), 32'(exp_err));
      check({tag, "_nbytes"}, 32'(got.size()), 32'(exp.size()));
      for (int i = 0; i < got.size() && i < exp.size(); i++)
        check({tag, "_byte"}, 32'(got[i]), 32'(exp[i]));
      check({tag, "_latency"}, 32'(cycles), 32'(1 + exp.size() + stalls));
    end
  endtask

  vec_t vecs[$];
  req_t rq;
  bq_t  eq;
  bit   eerr;
  int   st;

  initial begin
    rst_n = 1'b0; i_req_valid = 1'b0; i_byte_ready = 1'b0;
    drive_req('0);
    #1;
    check("rst_req_ready", 32'(o_req_ready), 32'd1);
    check("rst_byte_valid", 32'(o_byte_valid), 32'd0);
    check("rst_byte", 32'(o_byte), 32'h00);
    check("rst_done", 32'(o_done), 32'd0);
    check("rst_count", 32'(o_prefix_count), 32'd0);
    check("rst_error", 32'(o_error), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    vecs.push_back('{mk(1,0,0,1,3'd4,1,1), 32'hF0646667, 3'd4, 1'b0});
    vecs.push_back('{mk(0,0,0,0,3'd0,0,1), 32'h67000000, 3'd1, 1'b0});
    vecs.push_back('{mk(0,0,0,0,3'd0,0,0), 32'h00000000, 3'd0, 1'b0});
    vecs.push_back('{mk(0,1,1,0,3'd0,0,0), 32'h00000000, 3'd0, 1'b1});
    vecs.push_back('{mk(0,0,0,1,3'd7,0,0), 32'h00000000, 3'd0, 1'b1});
    vecs.push_back('{mk(0,0,1,1,3'd1,0,0), 32'hF32E0000, 3'd2, 1'b0});
    vecs.push_back('{mk(1,0,0,0,3'd0,1,0), 32'hF0660000, 3'd2, 1'b0});
    vecs.push_back('{mk(0,1,0,1,3'd5,0,1), 32'hF2656700, 3'd3, 1'b0});
    vecs.push_back('{mk(0,0,0,1,3'd0,0,0), 32'h26000000, 3'd1, 1'b0});
    vecs.push_back('{mk(0,0,0,1,3'd2,1,0), 32'h36660000, 3'd2, 1'b0});
    vecs.push_back('{mk(0,0,0,1,3'd3,0,0), 32'h3E000000, 3'd1, 1'b0});
    vecs.push_back('{mk(0,0,0,1,3'd6,1,1), 32'h00000000, 3'd0, 1'b1});
    vecs.push_back('{mk(1,0,1,0,3'd0,0,0), 32'h00000000, 3'd0, 1'b1});
    vecs.push_back('{mk(0,0,0,0,3'd7,1,0), 32'h66000000, 3'd1, 1'b0});
    vecs.push_back('{mk(1,1,1,1,3'd7,1,1), 32'h00000000, 3'd0, 1'b1});
`ifdef PREFIX_BRANCH_HINT_EN
    rq = mk(0,0,0,0,3'd0,1,0); rq.ht = 1;
    vecs.push_back('{rq, 32'h3E660000, 3'd2, 1'b0});
    rq = mk(0,0,0,1,3'd3,0,0); rq.ht = 1;
    vecs.push_back('{rq, 32'h00000000, 3'd0, 1'b1});
    rq = mk(0,0,0,0,3'd0,0,0); rq.ht = 1; rq.hnt = 1;
    vecs.push_back('{rq, 32'h00000000, 3'd0, 1'b1});
    rq = mk(0,0,0,0,3'd0,0,0); rq.hnt = 1;
    vecs.push_back('{rq, 32'h2E000000, 3'd1, 1'b0});
    rq = mk(1,0,0,0,3'd0,0,1); rq.hnt = 1;
    vecs.push_back('{rq, 32'hF02E6700, 3'd3, 1'b0});
`endif

    foreach (vecs[k])
      run_and_check("vec", vecs[k].req, to_q(vecs[k].bytes, int'(vecs[k].n)), vecs[k].err, 0, 0, st);

    // Backpressure: first byte stalled exactly three cycles.
    run_and_check("bp", mk(0,0,1,1,3'd1,0,0), to_q(32'hF32E0000, 2), 1'b0, 3, 0, st);
    check("bp_stalls", 32'(st), 32'd3);

    // Reset after the F0 handshake of lock+66.
    @(negedge clk);
    drive_req(mk(1,0,0,0,3'd0,1,0));
    i_req_valid = 1'b1; i_byte_ready = 1'b1;
    @(negedge clk);
    i_req_valid = 1'b0;
    check("rm_first_valid", 32'(o_byte_valid), 32'd1);
    check("rm_first_byte", 32'(o_byte), 32'hF0);
    @(negedge clk);
    check("rm_second_byte", 32'(o_byte), 32'h66);
    rst_n = 1'b0;
    #1;
    check("rm_req_ready", 32'(o_req_ready), 32'd1);
    check("rm_byte_valid", 32'(o_byte_valid), 32'd0);
    check("rm_byte", 32'(o_byte), 32'h00);
    check("rm_count", 32'(o_prefix_count), 32'd0);
    check("rm_error", 32'(o_error), 32'd0);
    repeat (3) begin
      @(negedge clk);
      check("rm_no_done", 32'(o_done), 32'd0);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("rm_after_done", 32'(o_done), 32'd0);
    run_and_check("rm_next", mk(1,0,0,0,3'd0,1,0), to_q(32'hF0660000, 2), 1'b0, 0, 0, st);

    for (int n = 0; n < 300; n++) begin
      rq = rand_req();
      model(rq, eq, eerr);
      run_and_check("rand", rq, eq, eerr, 0, int'($urandom_range(0, 60)), st);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
